// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline stages.
//   DATA_W            datapath width
//   REG_ADDR_W        register-file index width
//   DEFAULT_BASE_ADDR byte address mapped to data-memory word 0
//   mem_state_t       memory-stage access FSM states
package arm_pkg;

  localparam int unsigned DATA_W            = 32;
  localparam int unsigned REG_ADDR_W        = 4;
  localparam int unsigned DEFAULT_BASE_ADDR = 1024;

  typedef enum logic {
    IDLE,
    BUSY
  } mem_state_t;

endpackage

// File: rtl/data_mem.sv
// Word-addressed data memory: synchronous write, combinational read.
// Addresses outside [BASE_ADDR, BASE_ADDR + 4*DEPTH) read as 0 and ignore writes;
// address bits [1:0] are ignored.
// Ports:
//   clk_i       clock
//   we_i        write enable (committed at the rising edge when in range)
//   addr_i      byte address
//   wdata_i     write data
//   rdata_o     read data (0 when out of range)
//   in_range_o  address falls inside the memory window
module data_mem
  import arm_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              in_range_o
);

  localparam int unsigned       IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_W-1:0] Base = DATA_W'(BASE_ADDR);
  localparam logic [DATA_W-1:0] Span = DATA_W'(4 * DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] offset;
  logic [IdxW-1:0]   idx;

  // Offset wraps for addresses below the base, so both bounds are checked explicitly.
  assign offset     = addr_i - Base;
  assign in_range_o = (addr_i >= Base) && (offset < Span);
  assign idx        = offset[IdxW+1:2];
  assign rdata_o    = in_range_o ? mem_q[idx] : '0;

  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i && in_range_o) begin
      mem_q[idx] <= wdata_i;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage ARM pipeline: data memory with multi-cycle
// access timing, upstream stall generation and the MEM/WB pipeline register.
// Optional feature macro: MEM_STAGE_ERR_EN adds a registered mem_err output
// (out-of-range or misaligned access) and drops misaligned stores.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   WB_EN_in, MEM_R_in,
//   MEM_W_in, ALU_res_in,
//   val_rm_in, dest_in       EXE/MEM register outputs
//   freeze                   combinational stall request to upstream stages
//   WB_EN_out, MEM_R_out,
//   ALU_res_out,
//   mem_data_out, dest_out   MEM/WB register outputs
//   mem_err                  (MEM_STAGE_ERR_EN only) access error flag
module mem_stage
  import arm_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  WB_EN_in,
  input  logic                  MEM_R_in,
  input  logic                  MEM_W_in,
  input  logic [DATA_W-1:0]     ALU_res_in,
  input  logic [DATA_W-1:0]     val_rm_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  output logic                  freeze,
  output logic                  WB_EN_out,
  output logic                  MEM_R_out,
  output logic [DATA_W-1:0]     ALU_res_out,
  output logic [DATA_W-1:0]     mem_data_out,
`ifdef MEM_STAGE_ERR_EN
  output logic                  mem_err,
`endif
  output logic [REG_ADDR_W-1:0] dest_out
);

  localparam int unsigned     CntW   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(WAIT_CYCLES);

  mem_state_t            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  is_store, is_load, is_op;
  logic                  complete, freeze_int, store_ok;
  logic [DATA_W-1:0]     rdata;
  logic                  in_range;

  logic                  wb_en_q, mem_r_q;
  logic [DATA_W-1:0]     alu_res_q, mem_data_q;
  logic [REG_ADDR_W-1:0] dest_q;

  // A store wins when both requests are raised.
  assign is_store = MEM_W_in;
  assign is_load  = MEM_R_in & ~MEM_W_in;
  assign is_op    = is_store | is_load;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    complete   = 1'b0;
    freeze_int = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_op) begin
          if (WAIT_CYCLES == 0) begin
            complete = 1'b1;
          end else begin
            freeze_int = 1'b1;
            cnt_d      = CntW'(1);
            state_d    = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == CntMax) begin
          complete = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          freeze_int = 1'b1;
          cnt_d      = cnt_q + CntW'(1);
        end
      end
    endcase
  end

  assign freeze = freeze_int;

`ifdef MEM_STAGE_ERR_EN
  assign store_ok = is_store & complete & (ALU_res_in[1:0] == 2'b00);
`else
  assign store_ok = is_store & complete;
`endif

  data_mem #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR)
  ) u_data_mem (
    .clk_i      (clk),
    .we_i       (store_ok & ~rst),  // an access cut short by reset never commits
    .addr_i     (ALU_res_in),
    .wdata_i    (val_rm_in),
    .rdata_o    (rdata),
    .in_range_o (in_range)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MEM/WB register: bubble while stalled, otherwise load on idle or completion cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_q    <= 1'b0;
      mem_r_q    <= 1'b0;
      alu_res_q  <= '0;
      mem_data_q <= '0;
      dest_q     <= '0;
    end else if (freeze_int) begin
      wb_en_q <= 1'b0;
      mem_r_q <= 1'b0;
    end else begin
      wb_en_q   <= WB_EN_in;
      mem_r_q   <= is_load;
      alu_res_q <= ALU_res_in;
      dest_q    <= dest_in;
      if (complete && is_load) begin
        mem_data_q <= rdata;
      end
    end
  end

`ifdef MEM_STAGE_ERR_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (!freeze_int) begin
      err_q <= complete & (~in_range | (ALU_res_in[1:0] != 2'b00));
    end
  end
  assign mem_err = err_q;
`endif

  assign WB_EN_out    = wb_en_q;
  assign MEM_R_out    = mem_r_q;
  assign ALU_res_out  = alu_res_q;
  assign mem_data_out = mem_data_q;
  assign dest_out     = dest_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a word-array reference model.
module tb_mem_stage;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned BASE  = 1024;
  localparam int unsigned WAITC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        WB_EN_in, MEM_R_in, MEM_W_in;
  logic [31:0] ALU_res_in, val_rm_in;
  logic [3:0]  dest_in;
  logic        freeze, WB_EN_out, MEM_R_out;
  logic [31:0] ALU_res_out, mem_data_out;
  logic [3:0]  dest_out;
`ifdef MEM_STAGE_ERR_EN
  logic        mem_err;
`endif

  mem_stage #(
    .DEPTH       (DEPTH),
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .WB_EN_in     (WB_EN_in),
    .MEM_R_in     (MEM_R_in),
    .MEM_W_in     (MEM_W_in),
    .ALU_res_in   (ALU_res_in),
    .val_rm_in    (val_rm_in),
    .dest_in      (dest_in),
    .freeze       (freeze),
    .WB_EN_out    (WB_EN_out),
    .MEM_R_out    (MEM_R_out),
    .ALU_res_out  (ALU_res_out),
    .mem_data_out (mem_data_out),
`ifdef MEM_STAGE_ERR_EN
    .mem_err      (mem_err),
`endif
    .dest_out     (dest_out)
  );

  always #5 clk = ~clk;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  // Reference model state
  logic [31:0] mdl_mem [DEPTH];
  logic [31:0] exp_data = '0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit mdl_in_range(input logic [31:0] a);
    longint unsigned la = longint'(a);
    return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * longint'(DEPTH));
  endfunction

  function automatic int unsigned mdl_idx(input logic [31:0] a);
    return (int'(a) - int'(BASE)) / 4;
  endfunction

  task automatic drive(input logic w, input logic r, input logic wb, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] dst);
    MEM_W_in = w; MEM_R_in = r; WB_EN_in = wb;
    ALU_res_in = a; val_rm_in = d; dest_in = dst;
  endtask

  // Applies one EXE/MEM entry just after a rising edge and checks every cycle it occupies.
  task automatic run_op(input logic w, input logic r, input logic wb, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] dst);
    bit          op  = w | r;
    int          n   = op ? WAITC + 1 : 1;
    bit          inr = mdl_in_range(a);
    bit          mis = (a % 4) != 0;
    bit          do_store;
    drive(w, r, wb, a, d, dst);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check_eq("freeze", freeze, (c < n - 1) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      if (c < n - 1) begin
        check_eq("bubble_wb_en", WB_EN_out, 0);
        check_eq("bubble_mem_r", MEM_R_out, 0);
      end
    end
`ifdef MEM_STAGE_ERR_EN
    do_store = w && inr && !mis;
`else
    do_store = w && inr;
`endif
    if (do_store) mdl_mem[mdl_idx(a)] = d;
    if (r && !w) exp_data = inr ? mdl_mem[mdl_idx(a)] : 32'd0;
    check_eq("wb_en_out", WB_EN_out, wb);
    check_eq("mem_r_out", MEM_R_out, r & ~w);
    check_eq("alu_res_out", ALU_res_out, a);
    check_eq("dest_out", dest_out, dst);
    check_eq("mem_data_out", mem_data_out, exp_data);
`ifdef MEM_STAGE_ERR_EN
    check_eq("mem_err", mem_err, op && (!inr || mis));
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_freeze"}, freeze, 0);
    check_eq({tag, "_wb_en"}, WB_EN_out, 0);
    check_eq({tag, "_mem_r"}, MEM_R_out, 0);
    check_eq({tag, "_alu_res"}, ALU_res_out, 0);
    check_eq({tag, "_mem_data"}, mem_data_out, 0);
    check_eq({tag, "_dest"}, dest_out, 0);
`ifdef MEM_STAGE_ERR_EN
    check_eq({tag, "_err"}, mem_err, 0);
`endif
  endtask

  initial begin
    logic [31:0] a;
    int unsigned sel;
    rst = 1'b1;
    drive(0, 0, 0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Fill every word so later loads have defined contents
    for (int i = 0; i < int'(DEPTH); i++) begin
      run_op(1, 0, 0, BASE + 4 * i, $urandom, 4'(i));
    end

    // Directed cases
    run_op(1, 0, 0, 32'd1024, 32'hDEADBEEF, 4'd1);
    run_op(0, 1, 1, 32'd1024, 32'h0, 4'd2);
    check_eq("basic_load_data", mem_data_out, 32'hDEADBEEF);
    run_op(0, 0, 1, 32'h55, 32'h0, 4'd3);
    run_op(1, 0, 0, 32'd1028, 32'h11112222, 4'd4);
    run_op(1, 0, 0, 32'd1032, 32'h33334444, 4'd5);
    run_op(0, 1, 1, 32'd1028, 32'h0, 4'd6);
    check_eq("b2b_load_1028", mem_data_out, 32'h11112222);
    run_op(0, 1, 1, 32'd1032, 32'h0, 4'd7);
    check_eq("b2b_load_1032", mem_data_out, 32'h33334444);
    run_op(0, 1, 1, 32'h0, 32'h0, 4'd8);
    run_op(0, 1, 1, BASE + 4 * DEPTH, 32'h0, 4'd9);
    run_op(1, 0, 0, BASE + 4 * DEPTH, 32'hBAD0BAD0, 4'd9);
    run_op(0, 1, 1, 32'd1026, 32'h0, 4'd10);
    run_op(1, 1, 1, 32'd1036, 32'hCAFEF00D, 4'd11);
    run_op(0, 1, 1, 32'd1036, 32'h0, 4'd12);
    check_eq("priority_store_data", mem_data_out, 32'hCAFEF00D);

    // Reset in the final BUSY cycle of a store: it must not commit
    drive(1, 0, 0, 32'd1040, 32'h00001234, 4'd13);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 0, 0, '0, '0, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_data = '0;
    check_reset_outputs("midreset");
    run_op(0, 1, 1, 32'd1040, 32'h0, 4'd14);
    check_eq("midreset_old_value", mem_data_out == 32'h00001234, 0);

    // Random traffic
    for (int k = 0; k < 250; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)       a = BASE + 4 * $urandom_range(0, DEPTH - 1);
      else if (sel == 6) a = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
      else if (sel == 7) a = BASE - 4 * $urandom_range(1, 8);
      else if (sel == 8) a = BASE + 4 * DEPTH + 4 * $urandom_range(0, 8);
      else               a = $urandom;
      case ($urandom_range(0, 3))
        0:       run_op(0, 0, 1'($urandom), a, $urandom, 4'($urandom));
        1:       run_op(1, 1'($urandom), 1'($urandom), a, $urandom, 4'($urandom));
        default: run_op(0, 1, 1'($urandom), a, $urandom, 4'($urandom));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
